// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter in front of one shared memory slave.
// Read IDs go into an in-order FIFO so each slave response returns to the master that issued it.
module mem_arb2 #(
  parameter int RESP_FIFO_POW = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,

  output logic        err_o
);

  localparam int DEPTH = 1 << RESP_FIFO_POW;
  localparam logic [RESP_FIFO_POW:0]   CNT_FULL = (RESP_FIFO_POW+1)'(DEPTH);
  localparam logic [RESP_FIFO_POW:0]   CNT_ONE  = (RESP_FIFO_POW+1)'(1);
  localparam logic [RESP_FIFO_POW-1:0] PTR_ONE  = RESP_FIFO_POW'(1);

  logic [RESP_FIFO_POW-1:0] r_wptr;
  logic [RESP_FIFO_POW-1:0] r_rptr;
  logic [RESP_FIFO_POW:0]   r_count;
  logic                     r_id_mem [DEPTH];
  logic                     r_last_gnt;
  logic                     r_err;

  logic w_sel;
  logic w_any_req;
  logic w_stall;
  logic w_xfer;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Tie goes to the master that did not win the last accepted transfer
  always_comb begin
    w_sel = 1'b0;
    if (m0_req_i && m1_req_i) begin
      w_sel = ~r_last_gnt;
    end else if (m1_req_i) begin
      w_sel = 1'b1;
    end
  end

  assign w_any_req = m0_req_i | m1_req_i;
  assign w_stall   = (r_count == CNT_FULL);

  assign s_we_o     = w_sel ? m1_we_i     : m0_we_i;
  assign s_addr_bo  = w_sel ? m1_addr_bi  : m0_addr_bi;
  assign s_be_bo    = w_sel ? m1_be_bi    : m0_be_bi;
  assign s_wdata_bo = w_sel ? m1_wdata_bi : m0_wdata_bi;

  // Full FIFO blocks every request, even when a pop happens in the same cycle
  assign s_req_o  = w_any_req & ~w_stall & rstn_i;
  assign w_xfer   = s_req_o & s_ack_i;
  assign m0_ack_o = w_xfer & ~w_sel;
  assign m1_ack_o = w_xfer & w_sel;

  assign w_push = w_xfer & ~s_we_o;
  assign w_pop  = s_resp_i & (r_count != '0) & rstn_i;
  assign w_head = r_id_mem[r_rptr];

  assign m0_resp_o   = w_pop & ~w_head;
  assign m1_resp_o   = w_pop & w_head;
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

  assign err_o = r_err;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last_gnt <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_last_gnt <= w_sel;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (s_resp_i && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage is plain data; occupancy tracking makes stale entries harmless
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_id_mem[r_wptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: vector table for arbitration/routing plus sequences for FIFO-full and reset.
module tb_mem_arb2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        err;

  int n_chk = 0;
  int n_err = 0;
  logic sb[$];

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8000_0004;

  always #5 clk = ~clk;

  mem_arb2 #(.RESP_FIFO_POW(2)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
    .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
    .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
    .err_o(err)
  );

  typedef struct {
    logic        m0r, m0w, m1r, m1w, ack, resp;
    logic [31:0] rdata;
    logic        e_sreq, e_sel, e_m0a, e_m1a, e_m0p, e_m1p, e_err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic m0r, m0w, m1r, m1w, ack, resp,
                              input logic [31:0] rdata,
                              input logic e_sreq, e_sel, e_m0a, e_m1a, e_m0p, e_m1p, e_err);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w; v.ack = ack; v.resp = resp;
    v.rdata = rdata;
    v.e_sreq = e_sreq; v.e_sel = e_sel; v.e_m0a = e_m0a; v.e_m1a = e_m1a;
    v.e_m0p = e_m0p; v.e_m1p = e_m1p; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Responses pop the oldest outstanding read before this cycle's acks are pushed
  task automatic observe();
    logic exp_id;
    chk("resp_onehot", {31'd0, m0_resp & m1_resp}, 32'd0);
    if (m0_resp || m1_resp) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_unexpected_resp: got m0=%0b m1=%0b expected none", m0_resp, m1_resp);
      end else begin
        exp_id = sb.pop_front();
        chk("sb_resp_owner", {31'd0, m1_resp}, {31'd0, exp_id});
      end
    end
    if (m0_ack && !m0_we) sb.push_back(1'b0);
    if (m1_ack && !m1_we) sb.push_back(1'b1);
  endtask

  task automatic apply(input logic m0r, m0w, m1r, m1w, ack, resp, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    m0_req = m0r; m0_we = m0w; m1_req = m1r; m1_we = m1w;
    s_ack = ack; s_resp = resp; s_rdata = rdata;
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_sreq", {31'd0, s_req}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_resps", {30'd0, m1_resp, m0_resp}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    sb.delete();
    @(negedge clk);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_idle_sreq", {31'd0, s_req}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = A0; m0_be = 4'hF; m0_wdata = 32'hAAAA_0000;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = A1; m1_be = 4'h3; m1_wdata = 32'hBBBB_1111;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;

    //              m0r m0w m1r m1w ack rsp rdata          sreq sel m0a m1a m0p m1p err
    tbl[0]  = mk(1, 0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 1, 32'h1111_1111,  1, 1, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 32'h2222_2222,  0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 32'h3333_3333,  0, 0, 0, 0, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 32'h4444_4444,  0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 32'h5555_5555,  0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1);

    do_reset();

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].m0r, tbl[i].m0w, tbl[i].m1r, tbl[i].m1w, tbl[i].ack, tbl[i].resp, tbl[i].rdata);
      chk($sformatf("r%0d_sreq", i), {31'd0, s_req}, {31'd0, tbl[i].e_sreq});
      chk($sformatf("r%0d_m0ack", i), {31'd0, m0_ack}, {31'd0, tbl[i].e_m0a});
      chk($sformatf("r%0d_m1ack", i), {31'd0, m1_ack}, {31'd0, tbl[i].e_m1a});
      chk($sformatf("r%0d_m0resp", i), {31'd0, m0_resp}, {31'd0, tbl[i].e_m0p});
      chk($sformatf("r%0d_m1resp", i), {31'd0, m1_resp}, {31'd0, tbl[i].e_m1p});
      chk($sformatf("r%0d_m0rdata", i), m0_rdata, tbl[i].e_m0p ? tbl[i].rdata : 32'h0);
      chk($sformatf("r%0d_m1rdata", i), m1_rdata, tbl[i].e_m1p ? tbl[i].rdata : 32'h0);
      chk($sformatf("r%0d_err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
      if (tbl[i].m0r || tbl[i].m1r) begin
        chk($sformatf("r%0d_addr", i), s_addr, tbl[i].e_sel ? A1 : A0);
        chk($sformatf("r%0d_we", i), {31'd0, s_we},
            {31'd0, tbl[i].e_sel ? tbl[i].m1w : tbl[i].m0w});
      end
    end

    // FIFO full: four outstanding reads block the next request until a pop has landed
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 1, 0, 32'h0);
      chk($sformatf("fill%0d_m0ack", i), {31'd0, m0_ack}, 32'd1);
    end
    apply(1, 0, 1, 0, 1, 0, 32'h0);
    chk("full_sreq", {31'd0, s_req}, 32'd0);
    chk("full_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    apply(1, 0, 1, 0, 1, 1, 32'hA0A0_A0A0);
    chk("full_pop_m0resp", {31'd0, m0_resp}, 32'd1);
    chk("full_pop_rdata", m0_rdata, 32'hA0A0_A0A0);
    chk("full_pop_nobypass", {31'd0, s_req}, 32'd0);
    apply(1, 0, 1, 0, 1, 0, 32'h0);
    chk("unblock_sreq", {31'd0, s_req}, 32'd1);
    chk("unblock_m1ack", {31'd0, m1_ack}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 1, 32'hC000_0000 + 32'(i));
      chk($sformatf("drain%0d_resp", i), {31'd0, m0_resp | m1_resp}, 32'd1);
      chk($sformatf("drain%0d_rdata", i), m0_rdata | m1_rdata, 32'hC000_0000 + 32'(i));
    end
    chk("drain_sb_empty", sb.size(), 32'd0);

    // Reset with reads in flight: IDs are dropped and the tie goes back to m0
    apply(0, 0, 1, 0, 1, 0, 32'h0);
    chk("pre_m1ack", {31'd0, m1_ack}, 32'd1);
    apply(1, 0, 0, 0, 1, 0, 32'h0);
    chk("pre_m0ack", {31'd0, m0_ack}, 32'd1);
    do_reset();
    apply(0, 0, 0, 0, 0, 1, 32'h7777_7777);
    chk("stale_no_resp", {30'd0, m1_resp, m0_resp}, 32'd0);
    apply(1, 0, 1, 0, 1, 0, 32'h0);
    chk("stale_err", {31'd0, err}, 32'd1);
    chk("post_rst_tie_m0", {31'd0, m0_ack}, 32'd1);
    chk("post_rst_tie_m1", {31'd0, m1_ack}, 32'd0);
    apply(0, 0, 1, 0, 0, 1, 32'h9999_9999);
    chk("post_rst_resp", {31'd0, m0_resp}, 32'd1);
    chk("post_rst_rdata", m0_rdata, 32'h9999_9999);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter RESP_FIFO_POW, default 2, log2 of the maximum number of outstanding reads (depth 4).
REQ-002 Port clk_i, in, 1: single clock; all state updates on its rising edge.
REQ-003 Port rstn_i, in, 1: reset, synchronous and active-low.
REQ-004 Ports m0_req_i / m1_req_i, in, 1: request from master 0 / master 1.
REQ-005 Ports m0_we_i / m1_we_i, in, 1: 1 = write, 0 = read.
REQ-006 Ports m0_addr_bi / m1_addr_bi, in, 32: byte address.
REQ-007 Ports m0_be_bi / m1_be_bi, in, 4: byte enables.
REQ-008 Ports m0_wdata_bi / m1_wdata_bi, in, 32: write data.
REQ-009 Ports m0_ack_o / m1_ack_o, out, 1: request accepted this cycle.
REQ-010 Ports m0_resp_o / m1_resp_o, out, 1: read data valid.
REQ-011 Ports m0_rdata_bo / m1_rdata_bo, out, 32: read data.
REQ-012 Ports s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo, out, 1/1/32/4/32: request to the shared slave.
REQ-013 Ports s_ack_i, s_resp_i, s_rdata_bi, in, 1/1/32: slave accept, read response, read data.
REQ-014 Port err_o, out, 1: sticky flag, set on a slave response with no outstanding read.

Function
REQ-015 A transfer on any port SHALL occur in a cycle where its req and ack are both 1; masters hold request fields stable until ack.
REQ-016 Selection SHALL be combinational: only one master requesting -> that master is selected; both requesting -> the master other than last_gnt is selected; no request -> s_req_o = 0.
REQ-017 The s_we_o, s_addr_bo, s_be_bo and s_wdata_bo outputs SHALL mux the selected master's fields; s_req_o = selected req AND NOT stall.
REQ-018 The selected master's ack SHALL equal s_ack_i AND s_req_o; the unselected master's ack SHALL be 0.
REQ-019 last_gnt SHALL update to the accepted master's index only on a slave transfer (s_req_o & s_ack_i); a pending, unacked request does not rotate priority.
REQ-020 On an accepted read, the master index SHALL be pushed into an in-order ID FIFO of depth 2**RESP_FIFO_POW; writes push nothing and expect no response.
REQ-021 stall SHALL be 1 while the FIFO is full, blocking both reads and writes (no bypass on same-cycle pop); stall clears the cycle after a pop.
REQ-022 On s_resp_i with the FIFO non-empty, the head ID SHALL be popped, and the named master's resp_o = 1 with rdata_bo = s_rdata_bi in the same cycle (combinational, zero added latency).
REQ-023 A non-owner's resp_o SHALL be 0 and its rdata_bo SHALL be 0.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged, and pointers SHALL wrap modulo the depth.
REQ-025 The slave returns read responses in order with latency of 1 cycle or more.
REQ-026 A response in the same cycle as its own request is out of contract.
REQ-027 On s_resp_i with the FIFO empty: no master resp, err_o set to 1 and held until reset.
REQ-028 Occupancy counter SHALL be RESP_FIFO_POW+1 bits wide, range 0..2**RESP_FIFO_POW.

Reset
REQ-029 With rstn_i = 0 at a clock edge, the block SHALL clear FIFO pointers and occupancy to 0, set last_gnt = 1 (master 0 wins the first tie) and set err_o = 0.
REQ-030 While rstn_i = 0, the s_req_o, m0/m1 ack and m0/m1 resp outputs SHALL be forced to 0.
REQ-031 Reset mid-transaction SHALL discard outstanding IDs; responses arriving after reset hit the empty-FIFO rule (REQ-027).

Verification
REQ-032 Scenario: after reset, m0 and m1 both request reads at 0x80000000 / 0x80000004 with s_ack_i = 1 -> m0 is acked in cycle 0 and m1 in cycle 1; responses 0x11111111 then 0x22222222 go to m0 then m1.
REQ-033 Scenario: both masters request writes continuously with s_ack_i = 1 -> acks alternate m0, m1, m0, m1, with FIFO occupancy staying 0.
REQ-034 Scenario: m0 issues 4 reads with s_resp_i held 0 -> the 5th request (m0 or m1) sees s_req_o = 0; one response is routed to m0, and the blocked request is acked the next cycle.
REQ-035 Scenario: s_ack_i = 0 for 3 cycles while both request -> s_addr_bo stays on m0's address, last_gnt does not change, and m0 is acked when s_ack_i = 1.
REQ-036 Scenario: s_resp_i pulse with no outstanding read -> m0_resp_o = m1_resp_o = 0, err_o = 1 from the next cycle until rstn_i = 0.
REQ-037 Scenario: rstn_i driven low with 2 reads outstanding -> occupancy 0, next tie goes to m0, and err_o = 0.
